// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream raster frame generator with a counter-seeded moving gradient
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 24,
    parameter int COUNT_WIDTH = 32,
    parameter int FRAME_W     = 1920,
    parameter int FRAME_H     = 1080,
    parameter int FRAME_GAP   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   enable_i,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic                   frame_done_o,
    output logic                   busy_o
);
    localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
    localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1;
    localparam int GW = $clog2(FRAME_GAP + 1);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
    localparam logic [GW-1:0] G_LOAD = GW'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t          state;
    logic [XW-1:0]   x, x_nxt;
    logic [YW-1:0]   y, y_nxt;
    logic [GW-1:0]   gap;
    logic [15:0]     seed;
    logic            x_end, y_end, fire, start;
    logic            unused_count;

    assign unused_count = ^count_i;

    function automatic logic [23:0] pix(input logic [XW-1:0] px, input logic [YW-1:0] py, input logic [15:0] s);
        return {8'(px) + s[7:0], 8'(py) + s[7:0], s[15:8]};
    endfunction

    // next raster position and the frame-start condition
    always_comb begin
        x_end = x == X_LAST;
        y_end = y == Y_LAST;
        x_nxt = x_end ? '0 : x + XW'(1);
        y_nxt = x_end ? y + YW'(1) : y;
        fire  = m_axis_tvalid && m_axis_tready;
        start = enable_i && (state == IDLE || (state == GAP && gap == '0));
    end

    // frame sequencer with registered stream outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            gap           <= '0;
            seed          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (start) begin
                state         <= ACTIVE;
                seed          <= count_i[15:0];
                x             <= '0;
                y             <= '0;
                m_axis_tdata  <= DATA_WIDTH'(pix('0, '0, count_i[15:0]));
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= 1'b1;
                m_axis_tlast  <= X_LAST == '0;
                busy_o        <= 1'b1;
            end else begin
                case (state)
                    ACTIVE: if (fire) begin
                        if (x_end && y_end) begin
                            state         <= GAP;
                            gap           <= G_LOAD;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            frame_done_o  <= 1'b1;
                        end else begin
                            x            <= x_nxt;
                            y            <= y_nxt;
                            m_axis_tdata <= DATA_WIDTH'(pix(x_nxt, y_nxt, seed));
                            m_axis_tuser <= 1'b0;
                            m_axis_tlast <= x_nxt == X_LAST;
                        end
                    end
                    GAP: if (gap == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap <= gap - GW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: randomized self-checking bench against a frame-level reference model
module tb_axis_frame_gen;
    localparam int W = 4;
    localparam int H = 2;
    localparam int G = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] count_i = '0;
    logic        enable_i = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done_o;
    logic        busy_o;

    axis_frame_gen #(.DATA_WIDTH(24), .COUNT_WIDTH(32), .FRAME_W(W), .FRAME_H(H), .FRAME_GAP(G)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .count_i(count_i), .enable_i(enable_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done_o(frame_done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int done_seen = 0;
    logic [23:0] got[$];
    int starts[$];

    // reference model: phase 0 idle, 1 streaming beat k, 2 gap with gl low cycles elapsed
    int ph = 0;
    int k = 0;
    int gl = 0;
    bit dn = 0;
    logic [15:0] sd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] epix(input int kk, input logic [15:0] s);
        logic [7:0] r, g;
        r = 8'(((kk % W) + int'(s[7:0])) % 256);
        g = 8'(((kk / W) + int'(s[7:0])) % 256);
        return {r, g, s[15:8]};
    endfunction

    task automatic step(input bit en, input bit rdy, input logic [31:0] cnt);
        @(negedge clk_i);
        enable_i = en;
        m_axis_tready = rdy;
        count_i = cnt;
        check("tvalid", m_axis_tvalid, ph == 1);
        check("busy", busy_o, ph != 0);
        check("frame_done", frame_done_o, dn);
        if (ph == 1) begin
            check("tdata", m_axis_tdata, epix(k, sd));
            check("tuser", m_axis_tuser, k == 0);
            check("tlast", m_axis_tlast, (k % W) == W - 1);
        end
        if (frame_done_o) done_seen++;
        if (m_axis_tvalid && m_axis_tuser) starts.push_back(cyc);
        if (m_axis_tvalid && rdy) got.push_back(m_axis_tdata);
        dn = 0;
        case (ph)
            0: if (en) begin ph = 1; k = 0; sd = cnt[15:0]; end
            1: if (rdy) begin
                k++;
                if (k == W * H) begin ph = 2; gl = 1; dn = 1; end
            end
            default: if (gl == G) begin
                if (en) begin ph = 1; k = 0; sd = cnt[15:0]; end
                else ph = 0;
            end else gl++;
        endcase
        cyc++;
    endtask

    initial begin
        logic [31:0] c;
        #12;
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, $urandom);
            check("idle_tdata", m_axis_tdata, 0);
            check("idle_tuser", m_axis_tuser, 0);
            check("idle_tlast", m_axis_tlast, 0);
        end

        got.delete();
        done_seen = 0;
        step(1, 1, 32'h0000_1205);
        for (int i = 0; i < 16; i++) step(0, 1, $urandom);
        check("single_beats", got.size(), 8);
        if (got.size() == 8) begin
            check("single_beat0", got[0], 24'h050512);
            check("single_beat7", got[7], 24'h080612);
        end
        check("single_done_pulses", done_seen, 1);

        got.delete();
        for (int i = 0; i < 90; i++) step(1, 1'($urandom_range(0, 1)), $urandom);
        for (int i = 0; i < 60; i++) step(0, 1'($urandom_range(0, 1)), $urandom);
        check("bp_whole_frames", got.size() % 8, 0);

        starts.delete();
        c = $urandom;
        for (int i = 0; i < 60; i++) begin
            step(1, 1, c);
            c = c + 1;
        end
        for (int i = 0; i < 20; i++) step(0, 1, $urandom);
        check("cont_frames", starts.size() >= 5, 1);
        for (int i = 1; i < starts.size(); i++) check("cont_period", starts[i] - starts[i-1], W * H + G);

        got.delete();
        for (int i = 0; i < 3; i++) step(1, 1, $urandom);
        for (int i = 0; i < 20; i++) step(0, 1, $urandom);
        check("drop_beats", got.size(), 8);

        step(1, 1, $urandom);
        for (int i = 0; i < 20 && !(ph == 1 && k == 5); i++) step(0, 1, $urandom);
        check("areset_reached_beat5", k, 5);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("areset_tvalid", m_axis_tvalid, 0);
        check("areset_tdata", m_axis_tdata, 0);
        check("areset_tuser", m_axis_tuser, 0);
        check("areset_tlast", m_axis_tlast, 0);
        check("areset_busy", busy_o, 0);
        check("areset_done", frame_done_o, 0);
        ph = 0;
        dn = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        starts.delete();
        step(1, 1, $urandom);
        for (int i = 0; i < 15; i++) step(0, 1, $urandom);
        check("areset_restart_sof", starts.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
